// File: rtl/layer_compositor.sv
// Three-stage sprite-layer compositor: priority resolve, per-layer palette read, output register.
// Lowest eligible layer wins, colour index 0 is transparent, blinking layers drop out on phase 1.
module layer_compositor #(
  parameter int N_LAYERS     = 4,
  parameter int IDX_W        = 4,
  parameter int BLINK_FRAMES = 15,
  localparam int LW          = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1,
  localparam int HW          = $clog2(N_LAYERS) + 1
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      pix_valid_in,
  input  logic [N_LAYERS-1:0]       layer_hit,
  input  logic [N_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [23:0]               bg_color,
  input  logic [N_LAYERS-1:0]       blink_mask,
  input  logic                      frame_start,
  input  logic                      pal_we,
  input  logic [LW-1:0]             pal_layer,
  input  logic [IDX_W-1:0]          pal_addr,
  input  logic [23:0]               pal_wdata,
  output logic                      pix_valid_out,
  output logic [7:0]                Red,
  output logic [7:0]                Green,
  output logic [7:0]                Blue,
  output logic [HW-1:0]             hit_layer,
  output logic                      blink_phase
);

  localparam int CW    = $clog2(BLINK_FRAMES) + 1;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [HW-1:0] BG_CODE = HW'(N_LAYERS);

  logic [23:0]      pal_q [N_LAYERS][DEPTH];

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             blink_q, blink_d;

  logic             s1_valid_q;
  logic [HW-1:0]    s1_win_q, s1_win_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [23:0]      s1_bg_q;

  logic             s2_valid_q;
  logic [HW-1:0]    s2_win_q;
  logic [23:0]      s2_rgb_q, s2_rgb_d;

  logic             s3_valid_q;
  logic [HW-1:0]    s3_win_q;
  logic [23:0]      s3_rgb_q;

  // Blink timer: frame counter wraps at BLINK_FRAMES-1 and flips the phase on the same edge.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (frame_start) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  // Stage 1: scan from the lowest-priority layer upward so the lowest eligible index is kept.
  always_comb begin
    s1_win_d = BG_CODE;
    s1_idx_d = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (layer_hit[k] && (layer_idx[k*IDX_W +: IDX_W] != '0) && !(blink_mask[k] && blink_q)) begin
        s1_win_d = HW'(k);
        s1_idx_d = layer_idx[k*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_win_q   <= BG_CODE;
      s1_idx_q   <= '0;
      s1_bg_q    <= '0;
    end else begin
      s1_valid_q <= pix_valid_in;
      s1_win_q   <= s1_win_d;
      s1_idx_q   <= s1_idx_d;
      s1_bg_q    <= bg_color;
    end
  end

  // Stage 2: the palette read sees the array before this edge's write lands (read-before-write).
  always_comb begin
    s2_rgb_d = s1_bg_q;
    if (s1_win_q != BG_CODE) begin
      s2_rgb_d = pal_q[s1_win_q[LW-1:0]][s1_idx_q];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid_q <= 1'b0;
      s2_win_q   <= BG_CODE;
      s2_rgb_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_win_q   <= s1_win_q;
      s2_rgb_q   <= s2_rgb_d;
    end
  end

  // Palette writes only match real layers, so out-of-range pal_layer values fall through.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < N_LAYERS; k++) begin
        for (int a = 0; a < DEPTH; a++) begin
          pal_q[k][a] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < N_LAYERS; k++) begin
        if (pal_we && (pal_layer == LW'(k))) begin
          pal_q[k][pal_addr] <= pal_wdata;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s3_valid_q <= 1'b0;
      s3_win_q   <= BG_CODE;
      s3_rgb_q   <= '0;
    end else begin
      s3_valid_q <= s2_valid_q;
      s3_win_q   <= s2_win_q;
      s3_rgb_q   <= s2_rgb_q;
    end
  end

  assign pix_valid_out = s3_valid_q;
  assign Red           = s3_rgb_q[23:16];
  assign Green         = s3_rgb_q[15:8];
  assign Blue          = s3_rgb_q[7:0];
  assign hit_layer     = s3_win_q;
  assign blink_phase   = blink_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed vector table, multi-cycle corner sequences and random
// traffic scored against a transaction-level palette/priority model.
module tb_layer_compositor;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int BF = 15;

  logic        Clk, Reset_n, pix_valid_in, frame_start, pal_we;
  logic [3:0]  layer_hit, blink_mask, pal_addr;
  logic [15:0] layer_idx;
  logic [23:0] bg_color, pal_wdata;
  logic [1:0]  pal_layer;
  logic        pix_valid_out, blink_phase;
  logic [7:0]  Red, Green, Blue;
  logic [2:0]  hit_layer;

  logic        pal_we3;
  logic [1:0]  pal_layer3;
  logic        pv3, bp3;
  logic [7:0]  r3, g3, b3;
  logic [2:0]  hl3;

  layer_compositor #(.N_LAYERS(N), .IDX_W(IW), .BLINK_FRAMES(BF)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pix_valid_in), .layer_hit(layer_hit),
    .layer_idx(layer_idx), .bg_color(bg_color), .blink_mask(blink_mask),
    .frame_start(frame_start), .pal_we(pal_we), .pal_layer(pal_layer), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .pix_valid_out(pix_valid_out), .Red(Red), .Green(Green),
    .Blue(Blue), .hit_layer(hit_layer), .blink_phase(blink_phase)
  );

  // Three-layer instance: pal_layer=3 is unused, and a one-frame blink half-period.
  layer_compositor #(.N_LAYERS(3), .IDX_W(IW), .BLINK_FRAMES(1)) u_dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pix_valid_in), .layer_hit(layer_hit[2:0]),
    .layer_idx(layer_idx[11:0]), .bg_color(bg_color), .blink_mask(blink_mask[2:0]),
    .frame_start(frame_start), .pal_we(pal_we3), .pal_layer(pal_layer3), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .pix_valid_out(pv3), .Red(r3), .Green(g3),
    .Blue(b3), .hit_layer(hl3), .blink_phase(bp3)
  );

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- scoreboard / model ----------------
  int tests_run = 0;
  int tests_failed = 0;

  logic [23:0] pal_m [N][16];
  int          cnt_m;
  bit          ph_m;
  logic [27:0] exp_q[$];

  typedef struct {
    logic [3:0]  hit;
    logic [15:0] idx;
    logic [23:0] bg;
    logic        valid;
    logic [23:0] rgb;
    logic [2:0]  hl;
  } vec_t;
  vec_t tab[12];

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_winner();
    for (int k = 0; k < N; k++) begin
      if (layer_hit[k] && layer_idx[k*IW +: IW] != 4'd0 && !(blink_mask[k] && ph_m)) return k;
    end
    return N;
  endfunction

  task automatic init_model();
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 16; a++) pal_m[k][a] = 24'h0;
    cnt_m = 0;
    ph_m  = 1'b0;
    exp_q.delete();
    exp_q.push_back({1'b0, 3'd4, 24'h0});
    exp_q.push_back({1'b0, 3'd4, 24'h0});
  endtask

  // One pixel clock: predict this pixel, advance, then score the output leaving the pipe.
  task automatic cycle(input bit use_ovr = 1'b0, input logic [27:0] ovr = '0);
    int w;
    logic [23:0] rgb;
    w = ref_winner();
    if (pal_we) pal_m[pal_layer][pal_addr] = pal_wdata;
    rgb = (w == N) ? bg_color : pal_m[w][layer_idx[w*IW +: IW]];
    exp_q.push_back(use_ovr ? ovr : {pix_valid_in, 3'(w), rgb});
    if (frame_start) begin
      if (cnt_m == BF - 1) begin
        cnt_m = 0;
        ph_m  = !ph_m;
      end else begin
        cnt_m++;
      end
    end
    @(posedge Clk);
    #1;
    check("pipe", {pix_valid_out, hit_layer, Red, Green, Blue}, exp_q.pop_front());
    check("blink_phase", {27'd0, blink_phase}, {27'd0, ph_m});
  endtask

  task automatic pal_write(input logic [1:0] l, input logic [3:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_layer = l; pal_addr = a; pal_wdata = d;
    cycle();
    pal_we = 1'b0;
  endtask

  task automatic set_pix(input logic v, input logic [3:0] h, input logic [15:0] i,
                         input logic [23:0] bg);
    pix_valid_in = v; layer_hit = h; layer_idx = i; bg_color = bg;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {pix_valid_out, hit_layer, Red, Green, Blue}, {1'b0, 3'd4, 24'h0});
    check({name, "_blink"}, {27'd0, blink_phase}, 28'd0);
  endtask

  task automatic release_reset();
    frame_start = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    frame_start = 1'b0;
    init_model();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tab[0]  = '{4'b0011, 16'h0033, 24'h000000, 1'b1, 24'hFF0000, 3'd0};
    tab[1]  = '{4'b0011, 16'h0030, 24'h000000, 1'b1, 24'h00FF00, 3'd1};
    tab[2]  = '{4'b0000, 16'h0033, 24'h00BFFF, 1'b1, 24'h00BFFF, 3'd4};
    tab[3]  = '{4'b1100, 16'h1700, 24'h111111, 1'b1, 24'h0000FF, 3'd2};
    tab[4]  = '{4'b1000, 16'h1700, 24'h111111, 1'b1, 24'h808080, 3'd3};
    tab[5]  = '{4'b0100, 16'h1000, 24'h123456, 1'b1, 24'h123456, 3'd4};
    tab[6]  = '{4'b0001, 16'h0003, 24'h000000, 1'b0, 24'hFF0000, 3'd0};
    tab[7]  = '{4'b1111, 16'h1733, 24'h000000, 1'b1, 24'hFF0000, 3'd0};
    tab[8]  = '{4'b1110, 16'h1733, 24'h000000, 1'b1, 24'h00FF00, 3'd1};
    tab[9]  = '{4'b0001, 16'h0000, 24'h000000, 1'b1, 24'h000000, 3'd4};
    tab[10] = '{4'b0010, 16'h0030, 24'h000000, 1'b1, 24'h00FF00, 3'd1};
    tab[11] = '{4'b0001, 16'h0003, 24'hFFFFFF, 1'b1, 24'hFF0000, 3'd0};

    Reset_n = 1'b1; frame_start = 1'b0; pal_we = 1'b0; pal_layer = '0; pal_addr = '0;
    pal_wdata = '0; blink_mask = '0; pal_we3 = 1'b0; pal_layer3 = '0;
    set_pix(1'b0, 4'b0, 16'h0, 24'h0);
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    release_reset();

    // Palette setup.
    pal_write(2'd0, 4'd3, 24'hFF0000);
    pal_write(2'd1, 4'd3, 24'h00FF00);
    pal_write(2'd2, 4'd7, 24'h0000FF);
    pal_write(2'd3, 4'd1, 24'h808080);
    pal_write(2'd2, 4'd5, 24'hABCDEF);

    // Directed table streamed back-to-back.
    for (int i = 0; i < 12; i++) begin
      set_pix(tab[i].valid, tab[i].hit, tab[i].idx, tab[i].bg);
      cycle(1'b1, {tab[i].valid, tab[i].hl, tab[i].rgb});
    end
    set_pix(1'b0, 4'b0, 16'h0, 24'h0);
    repeat (3) cycle();

    // Blinking of layer 0 over 30 frames.
    blink_mask = 4'b0001;
    set_pix(1'b1, 4'b0011, 16'h0033, 24'h0);
    for (int f = 0; f < 30; f++) begin
      frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
      if (f == 13) check("blink_before_15", {27'd0, blink_phase}, 28'd0);
      if (f == 14) check("blink_after_15", {27'd0, blink_phase}, 28'd1);
      if (f == 29) check("blink_after_30", {27'd0, blink_phase}, 28'd0);
      cycle();
      cycle();
      cycle();
      if (f == 14) check("blink_winner_l1", {25'd0, hit_layer}, 28'd1);
      if (f == 29) check("blink_winner_l0", {25'd0, hit_layer}, 28'd0);
    end
    blink_mask = 4'b0000;

    // Read-before-write on palette[2][5].
    set_pix(1'b1, 4'b0100, 16'h0500, 24'h0);
    cycle(1'b1, {1'b1, 3'd2, 24'hABCDEF});
    pal_we = 1'b1; pal_layer = 2'd2; pal_addr = 4'd5; pal_wdata = 24'h123456;
    cycle(1'b1, {1'b1, 3'd2, 24'h123456});
    pal_we = 1'b0;
    cycle(1'b1, {1'b1, 3'd2, 24'h123456});
    set_pix(1'b0, 4'b0, 16'h0, 24'h0);
    repeat (3) cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_pix(1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom), 24'($urandom));
      blink_mask  = 4'($urandom);
      frame_start = ($urandom_range(0, 7) == 0);
      pal_we      = ($urandom_range(0, 3) == 0);
      pal_layer   = 2'($urandom);
      pal_addr    = 4'($urandom);
      pal_wdata   = 24'($urandom);
      cycle();
    end
    pal_we = 1'b0; frame_start = 1'b0; blink_mask = 4'b0;

    // Bring blink phase to 1, fill the pipe, then reset mid-stream.
    for (int i = 0; i < 2 * BF && !ph_m; i++) begin
      frame_start = 1'b1;
      cycle();
    end
    frame_start = 1'b0;
    check("phase_before_reset", {27'd0, blink_phase}, 28'd1);
    set_pix(1'b1, 4'b0001, 16'h0003, 24'h0);
    repeat (3) cycle();
    #1 Reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    release_reset();

    // Palette must read back cleared.
    set_pix(1'b1, 4'b0011, 16'h0033, 24'hFFFFFF);
    repeat (3) cycle(1'b1, {1'b1, 3'd0, 24'h000000});

    // Three-layer instance: out-of-range palette write and one-frame blink.
    check("n3_blink_reset", {27'd0, bp3}, 28'd0);
    pal_we3 = 1'b1; pal_layer3 = 2'd2; pal_addr = 4'd4; pal_wdata = 24'h0A0B0C;
    cycle();
    pal_layer3 = 2'd3; pal_wdata = 24'hFFFFFF;
    cycle();
    pal_we3 = 1'b0;
    for (int l = 0; l < 3; l++) begin
      set_pix(1'b1, 4'(1 << l), 16'h4444, 24'h0);
      repeat (3) cycle();
      check("n3_oor_write", {pv3, hl3, r3, g3, b3},
            {1'b1, 3'(l), (l == 2) ? 24'h0A0B0C : 24'h000000});
    end
    frame_start = 1'b1;
    cycle();
    check("n3_blink_1", {27'd0, bp3}, 28'd1);
    cycle();
    check("n3_blink_2", {27'd0, bp3}, 28'd0);
    frame_start = 1'b0;
    set_pix(1'b0, 4'b0, 16'h0, 24'h0);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
